// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter/receiver pair.
package uart_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_if.sv
// Byte-side and serial-line signals of uart_core; the core takes the slave side.
interface uart_if;

  logic [7:0] din;
  logic       send_start;
  logic       bit_out;
  logic       tx_busy;
  logic       bit_in;
  logic [7:0] dout;
  logic       dout_vld;
  logic       rx_frame_err;

  modport master (
    output din, send_start, bit_in,
    input  bit_out, tx_busy, dout, dout_vld, rx_frame_err
  );

  modport slave (
    input  din, send_start, bit_in,
    output bit_out, tx_busy, dout, dout_vld, rx_frame_err
  );

endinterface

// File: rtl/uart_rxd.sv
// 8N1 serial receiver with two-flop input synchronizer and mid-bit sampling.
module uart_rxd
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_40k,
  input  logic       rst,
  input  logic       bit_in,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       rx_frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, bit_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic             brk_q, brk_d;

  always_ff @(posedge clk_40k or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      bit_s_q  <= 1'b1;
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      sync1_q  <= bit_in;
      bit_s_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      brk_q    <= brk_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    brk_d    = brk_q;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d    = '0;
        bitcnt_d = '0;
        brk_d    = 1'b0;
        if (!bit_s_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = bit_s_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shreg_d = {bit_s_q, shreg_q[7:1]};
          if (bitcnt_q == BIT_LAST) state_d = RX_STOP;
          else                      bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        // After a low stop bit, hold here until the line releases so a break is not read as a start.
        if (brk_q) begin
          cnt_d = '0;
          if (bit_s_q) begin
            brk_d   = 1'b0;
            state_d = RX_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_s_q) begin
            dout_d  = shreg_q;
            vld_d   = 1'b1;
            state_d = RX_IDLE;
          end else begin
            err_d = 1'b1;
            brk_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign dout_vld     = vld_q;
  assign rx_frame_err = err_q;

endmodule

// File: rtl/uart_txd.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_txd
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_40k,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       send_start,
  output logic       bit_out,
  output logic       tx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             bit_out_q, bit_out_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk_40k or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      bit_out_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      bit_out_q <= bit_out_d;
      busy_q    <= busy_d;
    end
  end

  // bit_out is registered, so each branch sets the level for the next bit period.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    bit_out_d = bit_out_q;
    busy_d    = busy_q;
    unique case (state_q)
      TX_IDLE: begin
        cnt_d     = '0;
        bit_out_d = 1'b1;
        if (send_start) begin
          shreg_d   = din;
          bitcnt_d  = '0;
          busy_d    = 1'b1;
          bit_out_d = 1'b0;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          bit_out_d = shreg_q[0];
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bitcnt_q == BIT_LAST) begin
            bit_out_d = 1'b1;
            state_d   = TX_STOP;
          end else begin
            bitcnt_d  = bitcnt_q + 1'b1;
            shreg_d   = shreg_q >> 1;
            bit_out_d = shreg_q[1];
          end
        end
      end
      TX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign bit_out = bit_out_q;
  assign tx_busy = busy_q;

endmodule

// File: rtl/uart_core.sv
// UART core: independent transmitter and receiver sharing one clock and reset.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk_40k,
  input  logic rst,
  uart_if.slave bus
);

  uart_txd #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_txd (
    .clk_40k    (clk_40k),
    .rst        (rst),
    .din        (bus.din),
    .send_start (bus.send_start),
    .bit_out    (bus.bit_out),
    .tx_busy    (bus.tx_busy)
  );

  uart_rxd #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rxd (
    .clk_40k      (clk_40k),
    .rst          (rst),
    .bit_in       (bus.bit_in),
    .dout         (bus.dout),
    .dout_vld     (bus.dout_vld),
    .rx_frame_err (bus.rx_frame_err)
  );

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: loopback and directly driven serial line.
module tb_uart_core;

  localparam int unsigned CPB = 4;

  logic clk_40k = 1'b0;
  logic rst     = 1'b1;
  logic loop_en = 1'b1;
  logic drv_bit = 1'b1;

  int checks  = 0;
  int errors  = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  logic [7:0] rxq[$];

  uart_if bus();
  assign bus.bit_in = loop_en ? bus.bit_out : drv_bit;

  uart_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk_40k (clk_40k),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_40k = ~clk_40k;

  always @(negedge clk_40k) begin
    if (!rst) begin
      if (bus.dout_vld) begin
        vld_cnt++;
        rxq.push_back(bus.dout);
      end
      if (bus.rx_frame_err) err_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Expected line level in cycle i of a frame: start 0, data LSB first, stop 1.
  function automatic logic frame_level(input logic [7:0] b, input int i);
    int slot;
    slot = i / int'(CPB);
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    return b[3'(slot - 1)];
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (bus.tx_busy === 1'b1 && t < 200) begin
      @(negedge clk_40k);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle tx_busy got 1 want 0 within 200 cycles");
    end
  endtask

  // Returns at the negedge just after acceptance, i.e. frame cycle 0.
  task automatic send_byte(input logic [7:0] b);
    wait_idle();
    @(negedge clk_40k);
    bus.din        = b;
    bus.send_start = 1'b1;
    @(negedge clk_40k);
    bus.send_start = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int t = 0;
    while (vld_cnt < target && t < 200) begin
      @(negedge clk_40k);
      t++;
    end
    checks++;
    if (vld_cnt < target) begin
      errors++;
      $display("FAIL wait_rx dout_vld count got %0d want %0d", vld_cnt, target);
    end
  endtask

  task automatic check_pop(input string name, input logic [7:0] exp);
    logic [7:0] got;
    checks++;
    if (rxq.size() == 0) begin
      errors++;
      $display("FAIL %s dout got none want %02h", name, exp);
    end else begin
      got = rxq.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s dout got %02h want %02h", name, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    int base;
    bus.din        = '0;
    bus.send_start = 1'b0;
    rst            = 1'b1;
    repeat (2) @(negedge clk_40k);
    checks++;
    if (bus.bit_out !== 1'b1) begin errors++; $display("FAIL rst_bit_out got %b want 1", bus.bit_out); end
    checks++;
    if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL rst_tx_busy got %b want 0", bus.tx_busy); end
    checks++;
    if (bus.dout !== 8'h00) begin errors++; $display("FAIL rst_dout got %02h want 00", bus.dout); end
    checks++;
    if (bus.dout_vld !== 1'b0) begin errors++; $display("FAIL rst_dout_vld got %b want 0", bus.dout_vld); end
    checks++;
    if (bus.rx_frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %b want 0", bus.rx_frame_err); end
    rst = 1'b0;
    repeat (3) @(negedge clk_40k);

    loop_en = 1'b1;
    base    = vld_cnt;
    send_byte(8'($urandom));
    repeat (15) @(negedge clk_40k);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.bit_out !== 1'b1) begin errors++; $display("FAIL midrst_bit_out got %b want 1", bus.bit_out); end
    checks++;
    if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_tx_busy got %b want 0", bus.tx_busy); end
    repeat (2) @(negedge clk_40k);
    rst = 1'b0;
    repeat (60) @(negedge clk_40k);
    checks++;
    if (vld_cnt !== base) begin errors++; $display("FAIL midrst_no_vld count got %0d want %0d", vld_cnt, base); end
    rxq.delete();
  endtask

  task automatic test_loopback_single();
    int base;
    int lat = -1;
    loop_en = 1'b1;
    base    = vld_cnt;
    send_byte(8'hA5);
    for (int i = 0; i < 60; i++) begin
      if (i < 40) begin
        checks++;
        if (bus.bit_out !== frame_level(8'hA5, i)) begin
          errors++;
          $display("FAIL a5_bit_out cycle %0d got %b want %b", i, bus.bit_out, frame_level(8'hA5, i));
        end
      end
      checks++;
      if (bus.tx_busy !== (i < 40)) begin
        errors++;
        $display("FAIL a5_tx_busy cycle %0d got %b want %b", i, bus.tx_busy, (i < 40));
      end
      if (bus.dout_vld === 1'b1 && lat < 0) lat = i;
      @(negedge clk_40k);
    end
    checks++;
    if (lat != 2 + int'(CPB) / 2 + 9 * int'(CPB) + 1) begin
      errors++;
      $display("FAIL a5_latency edges got %0d want %0d", lat, 2 + int'(CPB) / 2 + 9 * int'(CPB) + 1);
    end
    checks++;
    if (vld_cnt !== base + 1) begin errors++; $display("FAIL a5_vld_count got %0d want %0d", vld_cnt - base, 1); end
    check_pop("a5_dout", 8'hA5);
  endtask

  task automatic test_loopback_random();
    int base;
    logic [7:0] b;
    loop_en = 1'b1;
    rxq.delete();
    base = vld_cnt;
    for (int n = 0; n < 20; n++) begin
      b = 8'($urandom);
      send_byte(b);
      wait_rx(base + n + 1);
      @(negedge clk_40k);
      check_pop("rand_dout", b);
    end
    repeat (50) @(negedge clk_40k);
    checks++;
    if (vld_cnt - base !== 20) begin errors++; $display("FAIL rand_vld_count got %0d want 20", vld_cnt - base); end
  endtask

  task automatic test_busy_drop();
    int base;
    loop_en = 1'b1;
    rxq.delete();
    base = vld_cnt;
    send_byte(8'h3C);
    repeat (5) @(negedge clk_40k);
    bus.din        = 8'hFF;
    bus.send_start = 1'b1;
    @(negedge clk_40k);
    bus.send_start = 1'b0;
    repeat (100) @(negedge clk_40k);
    checks++;
    if (vld_cnt - base !== 1) begin errors++; $display("FAIL drop_vld_count got %0d want 1", vld_cnt - base); end
    check_pop("drop_dout", 8'h3C);
    checks++;
    if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL drop_tx_busy got %b want 0", bus.tx_busy); end
  endtask

  task automatic test_framing();
    int vbase, ebase;
    logic [7:0] dout_before;
    logic [7:0] b;
    logic lvl;
    wait_idle();
    repeat (20) @(negedge clk_40k);
    rxq.delete();
    drv_bit = 1'b1;
    loop_en = 1'b0;
    vbase = vld_cnt;
    ebase = err_cnt;
    dout_before = bus.dout;

    @(negedge clk_40k) drv_bit = 1'b0;
    @(negedge clk_40k) drv_bit = 1'b1;
    repeat (20) @(negedge clk_40k);
    checks++;
    if (vld_cnt !== vbase) begin errors++; $display("FAIL glitch_vld got %0d want %0d", vld_cnt - vbase, 0); end
    checks++;
    if (err_cnt !== ebase) begin errors++; $display("FAIL glitch_err got %0d want %0d", err_cnt - ebase, 0); end

    b = 8'($urandom);
    for (int slot = 0; slot < 10; slot++) begin
      if (slot == 0 || slot == 9) lvl = 1'b0;
      else                        lvl = b[3'(slot - 1)];
      drv_bit = lvl;
      repeat (CPB) @(negedge clk_40k);
    end
    repeat (3 * CPB) @(negedge clk_40k);
    drv_bit = 1'b1;
    repeat (20) @(negedge clk_40k);
    checks++;
    if (err_cnt - ebase !== 1) begin errors++; $display("FAIL ferr_count got %0d want 1", err_cnt - ebase); end
    checks++;
    if (vld_cnt !== vbase) begin errors++; $display("FAIL ferr_vld got %0d want 0", vld_cnt - vbase); end
    checks++;
    if (bus.dout !== dout_before) begin errors++; $display("FAIL ferr_dout got %02h want %02h", bus.dout, dout_before); end

    loop_en = 1'b1;
    send_byte(8'h5A);
    wait_rx(vbase + 1);
    @(negedge clk_40k);
    check_pop("recover_dout", 8'h5A);
  endtask

  task automatic test_back_to_back();
    int base;
    int hi = 0;
    int gap = 0;
    int rises = 0;
    logic prev = 1'b0;
    logic done = 1'b0;
    loop_en = 1'b1;
    wait_idle();
    repeat (50) @(negedge clk_40k);
    rxq.delete();
    base = vld_cnt;
    bus.din        = 8'h00;
    bus.send_start = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk_40k);
      if (bus.tx_busy === 1'b1) begin
        hi++;
        if (!prev) begin
          rises++;
          if (rises == 1) bus.din = 8'hFF;
          else            bus.send_start = 1'b0;
        end
      end else begin
        if (rises == 1) gap++;
        if (rises == 2 && prev) done = 1'b1;
      end
      prev = bus.tx_busy;
    end
    bus.send_start = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL b2b_done got 0 want 1"); end
    checks++;
    if (hi !== 2 * 10 * int'(CPB)) begin errors++; $display("FAIL b2b_busy_cycles got %0d want %0d", hi, 20 * int'(CPB)); end
    checks++;
    if (gap !== 1) begin errors++; $display("FAIL b2b_idle_gap got %0d want 1", gap); end
    repeat (60) @(negedge clk_40k);
    checks++;
    if (vld_cnt - base !== 2) begin errors++; $display("FAIL b2b_vld_count got %0d want 2", vld_cnt - base); end
    check_pop("b2b_first", 8'h00);
    check_pop("b2b_second", 8'hFF);
  endtask

  initial begin
    test_reset();
    test_loopback_single();
    test_loopback_random();
    test_busy_drop();
    test_framing();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
